// File: rtl/board_ctrl_pkg.sv
// Shared types and constants for the board-glue controller.
// Holds the sequencer state encoding and fixed LED positions.
package board_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        BOOT      = 2'd3
    } board_state_t;

    localparam int LED_ACT  = 0;
    localparam int LED_BOOT = 1;

endpackage

// File: rtl/board_ctrl_seq_btn_debounce.sv
// One button: polarity fix, 2-flop synchroniser, stability counter and press pulse.
// btn_level only flips after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int   DEBOUNCE_CYCLES = 480000,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw ^ ACTIVE_LOW;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // press pulses only on the rising flip of the debounced level
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/board_ctrl_seq.sv
// Board-glue controller: debounced buttons, core reset sequencing from PLL lock,
// long-press / core-requested boot commit, and LED status with heartbeat.
module board_ctrl_seq
    import board_ctrl_pkg::*;
#(
    parameter int                 NUM_BTN           = 7,
    parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW    = 7'b0000001,
    parameter int                 DEBOUNCE_CYCLES   = 480000,
    parameter int                 RESET_BTN         = 0,
    parameter int                 BOOT_BTN          = 1,
    parameter int                 LONG_PRESS_CYCLES = 96000000,
    parameter int                 RESET_HOLD_CYCLES = 4800,
    parameter int                 NUM_LED           = 8,
    parameter int                 BLINK_CYCLES      = 12000000
) (
    input  logic               clk_48mhz,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               bl_led,
    input  logic               bl_boot,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               core_reset,
    output logic               boot_out,
    output logic [NUM_LED-1:0] led
);

    localparam int            HW         = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int            LW         = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW[i])
        ) u_debounce (
            .clk    (clk_48mhz),
            .reset_n(reset_n),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
        );
    end

    board_state_t      state, state_d;
    logic              lock_s1, lock_s2;
    logic [HW-1:0]     hold_cnt, hold_d;
    logic [LW-1:0]     long_cnt, long_d;
    logic [BW-1:0]     blink_cnt, blink_d;
    logic              hb, hb_d;
    logic [NUM_LED-1:0] led_d;
    logic              rst_btn, boot_btn;

    assign rst_btn  = btn_level[RESET_BTN];
    assign boot_btn = btn_level[BOOT_BTN];

    always_comb begin
        state_d = state;
        hold_d  = '0;
        long_d  = '0;
        blink_d = '0;
        hb_d    = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_s2) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s2) begin
                    state_d = WAIT_LOCK;
                end else if (rst_btn) begin
                    hold_d = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            RUN: begin
                if (boot_btn) begin
                    long_d = (long_cnt == LONG_LAST) ? long_cnt : long_cnt + LW'(1);
                end
                if (blink_cnt == BLINK_LAST) begin
                    hb_d = ~hb;
                end else begin
                    blink_d = blink_cnt + BW'(1);
                    hb_d    = hb;
                end
                // lock loss beats the reset button, which beats any boot request
                if (!lock_s2) begin
                    state_d = WAIT_LOCK;
                end else if (rst_btn) begin
                    state_d = HOLD;
                end else if (bl_boot || (boot_btn && long_cnt == LONG_LAST)) begin
                    state_d = BOOT;
                end
            end
            BOOT: begin
                state_d = BOOT;
            end
            default: state_d = WAIT_LOCK;
        endcase

        // outputs are registered from the next state so they move with it
        led_d           = '0;
        led_d[LED_ACT]  = (state_d == RUN) && bl_led;
        led_d[LED_BOOT] = (state_d == BOOT);
        case (state_d)
            HOLD, BOOT: led_d[NUM_LED-1] = 1'b1;
            RUN:        led_d[NUM_LED-1] = hb_d;
            default:    led_d[NUM_LED-1] = 1'b0;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            lock_s1    <= 1'b0;
            lock_s2    <= 1'b0;
            hold_cnt   <= '0;
            long_cnt   <= '0;
            blink_cnt  <= '0;
            hb         <= 1'b0;
            core_reset <= 1'b1;
            boot_out   <= 1'b0;
            led        <= '0;
        end else begin
            state      <= state_d;
            lock_s1    <= pll_locked;
            lock_s2    <= lock_s1;
            hold_cnt   <= hold_d;
            long_cnt   <= long_d;
            blink_cnt  <= blink_d;
            hb         <= hb_d;
            core_reset <= !(state_d == RUN || state_d == BOOT);
            boot_out   <= (state_d == BOOT);
            led        <= led_d;
        end
    end

endmodule

// File: tb/tb_board_ctrl_seq.sv
// Directed bench for board_ctrl_seq with small counter parameters.
// Drivers push expected output snapshots; a negedge monitor pops and compares them.
module tb_board_ctrl_seq;

    localparam int W = 14;

    logic       clk_48mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       pll_locked = 1'b0;
    logic [1:0] btn_raw   = 2'b01;
    logic       bl_led    = 1'b0;
    logic       bl_boot   = 1'b0;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic       core_reset;
    logic       boot_out;
    logic [7:0] led;

    board_ctrl_seq #(
        .NUM_BTN          (2),
        .BTN_ACTIVE_LOW   (2'b01),
        .DEBOUNCE_CYCLES  (4),
        .RESET_BTN        (0),
        .BOOT_BTN         (1),
        .LONG_PRESS_CYCLES(20),
        .RESET_HOLD_CYCLES(8),
        .NUM_LED          (8),
        .BLINK_CYCLES     (5)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .btn_raw   (btn_raw),
        .bl_led    (bl_led),
        .bl_boot   (bl_boot),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .core_reset(core_reset),
        .boot_out  (boot_out),
        .led       (led)
    );

    // clock / reset
    always #5 clk_48mhz = ~clk_48mhz;

    // output snapshot layout: {level[1:0], press[1:0], core_reset, boot_out, led[7:0]}
    function automatic logic [W-1:0] pk(input logic [1:0] lvl, input logic [1:0] prs,
                                        input logic cr, input logic bo, input logic [7:0] ld);
        return {lvl, prs, cr, bo, ld};
    endfunction

    localparam logic [W-1:0] M_ALL = {W{1'b1}};
    localparam logic [W-1:0] M_CR  = 14'b00_00_1_0_00000000;
    localparam logic [W-1:0] M_BO  = 14'b00_00_0_1_00000000;
    localparam logic [W-1:0] M_LED = 14'b00_00_0_0_11111111;
    localparam logic [W-1:0] M_L0  = 14'b01_00_0_0_00000000;
    localparam logic [W-1:0] M_L1  = 14'b10_00_0_0_00000000;
    localparam logic [W-1:0] M_P0  = 14'b00_01_0_0_00000000;
    localparam logic [W-1:0] M_P1  = 14'b00_10_0_0_00000000;

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always @(negedge clk_48mhz) begin
        logic [W-1:0] obs, e, m;
        string        n;
        obs = pk(btn_level, btn_press, core_reset, boot_out, led);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            n = name_q.pop_front();
            n_tests++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (mask %h)", n, obs & m, e & m, m);
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk_48mhz);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] m, input logic [W-1:0] v);
        exp_q.push_back(v);
        mask_q.push_back(m);
        name_q.push_back(name);
    endtask

    task automatic power_up();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        btn_raw    = 2'b01;
        bl_led     = 1'b1;
        bl_boot    = 1'b0;
        step(2);
        chk("reset_values", M_ALL, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));
        reset_n = 1'b1;
        step(10);
        chk("wait_lock", M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));
        pll_locked = 1'b1;
        step(2);
        chk("lock_sync", M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));
        step(1);
        chk("hold_entry", M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h80));
        step(7);
        chk("hold_last", M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h80));
        step(1);
        chk("run_entry", M_CR | M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h01));
    endtask

    initial begin
        // power-up and heartbeat, then mid-run reset
        power_up();
        step(4);  chk("hb_low_a",  M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h01));
        step(1);  chk("hb_high_a", M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h81));
        step(4);  chk("hb_high_b", M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h81));
        step(1);  chk("hb_low_b",  M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h01));
        step(5);  chk("hb_high_c", M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h81));
        step(5);  chk("hb_low_c",  M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h01));
        step(2);  chk("hb_low_22", M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h01));
        bl_led = 1'b0;
        step(1);  chk("act_led_off", M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        reset_n = 1'b0;
        step(1);  chk("midrun_reset", M_ALL, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));

        // debounce: short glitch ignored, steady press latches with a single pulse
        power_up();
        btn_raw = 2'b11;
        step(3);
        btn_raw = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_ignored", M_L1 | M_P1, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        end
        btn_raw = 2'b11;
        step(5);  chk("deb_not_yet", M_L1 | M_P1, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        step(1);  chk("deb_rise",    M_L1 | M_P1, pk(2'b10, 2'b10, 1'b0, 1'b0, 8'h00));
        step(1);  chk("press_single", M_L1 | M_P1, pk(2'b10, 2'b00, 1'b0, 1'b0, 8'h00));
        btn_raw = 2'b01;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("release_no_pulse", M_L1 | M_P1 | M_CR,
                pk((i < 5) ? 2'b10 : 2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        end

        // reset button forces HOLD, then re-runs the hold count after release
        power_up();
        btn_raw = 2'b00;
        step(6);  chk("rstbtn_level", M_L0 | M_P0 | M_CR, pk(2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
        step(1);  chk("rstbtn_hold", M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h80));
        step(23); chk("rstbtn_held", M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h80));
        btn_raw = 2'b01;
        step(6);  chk("rstbtn_release", M_L0 | M_CR, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));
        step(7);  chk("rstbtn_hold_end", M_CR, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));
        step(1);  chk("rstbtn_run", M_CR | M_LED, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h01));

        // long press: too short is ignored, full length commits boot, boot is terminal
        power_up();
        btn_raw = 2'b11;
        step(18);
        btn_raw = 2'b01;
        step(8);  chk("short_hold_a", M_BO | M_CR, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        step(10); chk("short_hold_b", M_BO | M_CR, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        btn_raw = 2'b11;
        step(25); chk("long_not_yet", M_BO | M_CR, pk(2'b00, 2'b00, 1'b0, 1'b0, 8'h00));
        step(1);  chk("long_boot", M_BO | M_CR | M_LED, pk(2'b00, 2'b00, 1'b0, 1'b1, 8'h82));
        step(4);
        btn_raw    = 2'b00;
        pll_locked = 1'b0;
        step(12); chk("boot_terminal", M_BO | M_CR | M_LED | M_L0,
                      pk(2'b01, 2'b00, 1'b0, 1'b1, 8'h82));

        // core boot flag commits immediately and sticks
        power_up();
        bl_boot = 1'b1;
        step(1);  chk("blboot_commit", M_BO | M_CR | M_LED, pk(2'b00, 2'b00, 1'b0, 1'b1, 8'h82));
        bl_boot = 1'b0;
        step(3);  chk("blboot_sticky", M_BO | M_CR, pk(2'b00, 2'b00, 1'b0, 1'b1, 8'h00));

        // reset button wins over a simultaneous core boot flag
        power_up();
        btn_raw = 2'b00;
        step(6);
        bl_boot = 1'b1;
        step(1);  chk("rst_beats_boot", M_BO | M_CR | M_LED, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h80));
        bl_boot = 1'b0;
        step(2);  chk("rst_beats_boot_b", M_BO | M_CR, pk(2'b00, 2'b00, 1'b1, 1'b0, 8'h00));

        // final report
        @(negedge clk_48mhz);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
